// File: rtl/bus_sched_pkg.sv
// Shared types and constants for the three-requester bus scheduler.
package bus_sched_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } sched_state_e;

    localparam int REQ_NUM    = 3;
    localparam int REQ_DCACHE = 0;
    localparam int REQ_ICACHE = 1;
    localparam int REQ_LOADER = 2;

    // Keeps only the lowest set bit, i.e. the base-priority winner of a set.
    function automatic logic [REQ_NUM-1:0] lowest_one(input logic [REQ_NUM-1:0] v);
        return v & (~v + {{(REQ_NUM-1){1'b0}}, 1'b1});
    endfunction

endpackage

// File: rtl/bus_sched_pick.sv
// Combinational winner selection: starved requesters first, then base priority.
module bus_sched_pick
    import bus_sched_pkg::*;
#(
    parameter int STARVE_LIMIT = 8,
    parameter int AGE_W        = 4
) (
    input  logic [REQ_NUM-1:0]            pending,
    input  logic [REQ_NUM-1:0][AGE_W-1:0] age,
    output logic [REQ_NUM-1:0]            winner
);

    localparam logic [AGE_W-1:0] LIMIT = AGE_W'(STARVE_LIMIT);

    logic [REQ_NUM-1:0] starved_s;

    // Any starved requester narrows the candidate set to the starved ones.
    always_comb begin
        starved_s = {REQ_NUM{1'b0}};
        for (int i = 0; i < REQ_NUM; i++) begin
            starved_s[i] = pending[i] && (age[i] >= LIMIT);
        end
        if (|starved_s) begin
            winner = lowest_one(starved_s);
        end else begin
            winner = lowest_one(pending);
        end
    end

endmodule

// File: rtl/bus_scheduler.sv
// Three-requester memory bus scheduler with starvation promotion.
// Define BUS_SCHED_TIMEOUT_EN to add the BUSY watchdog that aborts with err_o.
module bus_scheduler
    import bus_sched_pkg::*;
#(
    parameter int  BUS_ADDRESS_WIDTH    = 20,
    parameter int  BUS_DATA_WIDTH_SHIFT = 4,
    parameter int  STARVE_LIMIT         = 8,
    parameter int  TIMEOUT_CYCLES       = 255,
    localparam int BUS_DATA_WIDTH       = (2 ** BUS_DATA_WIDTH_SHIFT) * 8,
    localparam int LINE_W               = BUS_ADDRESS_WIDTH - BUS_DATA_WIDTH_SHIFT
) (
    input  logic                                        clk_i,
    input  logic                                        rst_i,
    input  logic [REQ_NUM-1:0]                          req_valid_i,
    input  logic [REQ_NUM-1:0]                          req_we_i,
    input  logic [REQ_NUM*LINE_W-1:0]                   req_addr_i,
    input  logic [REQ_NUM*BUS_DATA_WIDTH-1:0]           req_data_i,
    output logic [REQ_NUM-1:0]                          grant_o,
    output logic [REQ_NUM-1:0]                          done_o,
    output logic                                        err_o,
    output logic [BUS_DATA_WIDTH-1:0]                   rdata_o,
    output logic [BUS_ADDRESS_WIDTH-1:BUS_DATA_WIDTH_SHIFT] bus_addr_o,
    output logic [BUS_DATA_WIDTH-1:0]                   bus_data_o,
    output logic                                        bus_we_o,
    output logic                                        bus_valid_o,
    input  logic [BUS_DATA_WIDTH-1:0]                   bus_data_i,
    input  logic                                        bus_valid_i
);

    localparam int               AGE_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(STARVE_LIMIT);

    sched_state_e                  state_r;
    logic [REQ_NUM-1:0][AGE_W-1:0] age_r;
    logic [REQ_NUM-1:0]            winner_s;
    logic [LINE_W-1:0]             sel_addr_s;
    logic [BUS_DATA_WIDTH-1:0]     sel_data_s;
    logic                          sel_we_s;

`ifdef BUS_SCHED_TIMEOUT_EN
    localparam int              WD_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] wd_r;
    logic            err_r;

    assign err_o = err_r;
`else
    assign err_o = 1'b0;
`endif

    bus_sched_pick #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .AGE_W        (AGE_W)
    ) u_pick (
        .pending (req_valid_i),
        .age     (age_r),
        .winner  (winner_s)
    );

    // One-hot AND-OR mux of the winner's request fields.
    always_comb begin
        sel_addr_s = {LINE_W{1'b0}};
        sel_data_s = {BUS_DATA_WIDTH{1'b0}};
        sel_we_s   = 1'b0;
        for (int i = 0; i < REQ_NUM; i++) begin
            sel_addr_s = sel_addr_s | ({LINE_W{winner_s[i]}} & req_addr_i[i*LINE_W +: LINE_W]);
            sel_data_s = sel_data_s | ({BUS_DATA_WIDTH{winner_s[i]}} & req_data_i[i*BUS_DATA_WIDTH +: BUS_DATA_WIDTH]);
            sel_we_s   = sel_we_s | (winner_s[i] & req_we_i[i]);
        end
    end

    // Scheduler FSM with registered bus, grant, completion and age state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r     <= IDLE;
            grant_o     <= {REQ_NUM{1'b0}};
            done_o      <= {REQ_NUM{1'b0}};
            rdata_o     <= {BUS_DATA_WIDTH{1'b0}};
            bus_addr_o  <= {LINE_W{1'b0}};
            bus_data_o  <= {BUS_DATA_WIDTH{1'b0}};
            bus_we_o    <= 1'b0;
            bus_valid_o <= 1'b0;
            age_r       <= {REQ_NUM{{AGE_W{1'b0}}}};
`ifdef BUS_SCHED_TIMEOUT_EN
            err_r       <= 1'b0;
            wd_r        <= {WD_W{1'b0}};
`endif
        end else begin
            done_o <= {REQ_NUM{1'b0}};
`ifdef BUS_SCHED_TIMEOUT_EN
            err_r  <= 1'b0;
`endif
            case (state_r)
                IDLE: begin
                    if (|req_valid_i) begin
                        state_r     <= BUSY;
                        grant_o     <= winner_s;
                        bus_addr_o  <= sel_addr_s;
                        bus_data_o  <= sel_data_s;
                        bus_we_o    <= sel_we_s;
                        bus_valid_o <= 1'b1;
`ifdef BUS_SCHED_TIMEOUT_EN
                        wd_r        <= {WD_W{1'b0}};
`endif
                        // Losers that were pending age; the winner starts fresh.
                        for (int i = 0; i < REQ_NUM; i++) begin
                            if (winner_s[i]) begin
                                age_r[i] <= {AGE_W{1'b0}};
                            end else if (req_valid_i[i] && (age_r[i] < AGE_MAX)) begin
                                age_r[i] <= age_r[i] + AGE_W'(1);
                            end else begin
                                age_r[i] <= age_r[i];
                            end
                        end
                    end else begin
                        grant_o     <= {REQ_NUM{1'b0}};
                        bus_valid_o <= 1'b0;
                    end
                end
                BUSY: begin
                    if (bus_valid_i) begin
                        rdata_o     <= bus_data_i;
                        done_o      <= grant_o;
                        grant_o     <= {REQ_NUM{1'b0}};
                        bus_valid_o <= 1'b0;
                        state_r     <= IDLE;
                    end
`ifdef BUS_SCHED_TIMEOUT_EN
                    else if (wd_r == WD_LAST) begin
                        done_o      <= grant_o;
                        err_r       <= 1'b1;
                        grant_o     <= {REQ_NUM{1'b0}};
                        bus_valid_o <= 1'b0;
                        state_r     <= IDLE;
                        wd_r        <= {WD_W{1'b0}};
                    end else begin
                        wd_r <= wd_r + WD_W'(1);
                    end
`else
                    else begin
                        bus_valid_o <= 1'b1;
                    end
`endif
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_scheduler.sv
// Randomized bench for bus_scheduler against a transaction-level reference model.
module tb_bus_scheduler;
    import bus_sched_pkg::*;

    localparam int AW = 20;
    localparam int SH = 4;
    localparam int DW = 128;
    localparam int LW = AW - SH;
    localparam int SL = 8;
    localparam int TO = 16;
    localparam logic [DW-1:0] RD_CONST = 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  rst_i;
    logic [2:0]            req_valid_i, req_we_i;
    logic [3*LW-1:0]       req_addr_i;
    logic [3*DW-1:0]       req_data_i;
    logic [2:0]            grant_o, done_o;
    logic                  err_o;
    logic [DW-1:0]         rdata_o, bus_data_o, bus_data_i;
    logic [AW-1:SH]        bus_addr_o;
    logic                  bus_we_o, bus_valid_o, bus_valid_i;

    bus_scheduler #(
        .BUS_ADDRESS_WIDTH    (AW),
        .BUS_DATA_WIDTH_SHIFT (SH),
        .STARVE_LIMIT         (SL),
        .TIMEOUT_CYCLES       (TO)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .req_valid_i (req_valid_i),
        .req_we_i    (req_we_i),
        .req_addr_i  (req_addr_i),
        .req_data_i  (req_data_i),
        .grant_o     (grant_o),
        .done_o      (done_o),
        .err_o       (err_o),
        .rdata_o     (rdata_o),
        .bus_addr_o  (bus_addr_o),
        .bus_data_o  (bus_data_o),
        .bus_we_o    (bus_we_o),
        .bus_valid_o (bus_valid_o),
        .bus_data_i  (bus_data_i),
        .bus_valid_i (bus_valid_i)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit chk_en = 1'b0;

    // Reference model: what the outputs must be after the most recent edge.
    bit            m_busy, m_new, m_bvalid, m_err, m_we;
    int            m_owner, m_busy_cyc;
    int            m_age[3];
    logic [2:0]    m_grant, m_done;
    logic [DW-1:0] m_rdata, m_data;
    logic [LW-1:0] m_addr;

    // Stimulus controls.
    logic [2:0]    hold_mask = 3'b000;
    bit            rnd_mode = 1'b0, auto_bus = 1'b1, resp_fixed = 1'b0;
    int            fixed_lat = 2, lat_cnt = 0;
    logic [DW-1:0] resp_data = RD_CONST;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h, want %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic finish_txn(input bit aborted);
        m_done   = m_grant;
        m_err    = aborted;
        m_grant  = 3'b000;
        m_bvalid = 1'b0;
        m_busy   = 1'b0;
    endtask

    // Applies the scheduling rules to the inputs present at this edge.
    task automatic model_edge();
        m_done = 3'b000;
        m_err  = 1'b0;
        m_new  = 1'b0;
        if (rst_i) begin
            m_busy = 1'b0; m_grant = 3'b000; m_bvalid = 1'b0; m_we = 1'b0;
            m_addr = '0; m_data = '0; m_rdata = '0; m_busy_cyc = 0;
            for (int i = 0; i < REQ_NUM; i++) m_age[i] = 0;
        end else if (!m_busy) begin
            if (req_valid_i != 3'b000) begin
                int w;
                w = -1;
                for (int i = 0; i < REQ_NUM; i++)
                    if (w < 0 && req_valid_i[i] && m_age[i] >= SL) w = i;
                for (int i = 0; i < REQ_NUM; i++)
                    if (w < 0 && req_valid_i[i]) w = i;
                for (int i = 0; i < REQ_NUM; i++) begin
                    if (i == w) m_age[i] = 0;
                    else if (req_valid_i[i] && m_age[i] < SL) m_age[i]++;
                end
                m_busy = 1'b1; m_new = 1'b1; m_owner = w; m_busy_cyc = 0;
                m_grant  = 3'b001 << w;
                m_bvalid = 1'b1;
                m_addr   = req_addr_i[w*LW +: LW];
                m_data   = req_data_i[w*DW +: DW];
                m_we     = req_we_i[w];
            end
        end else if (bus_valid_i) begin
            m_rdata = bus_data_i;
            finish_txn(1'b0);
        end else begin
            m_busy_cyc++;
`ifdef BUS_SCHED_TIMEOUT_EN
            if (m_busy_cyc == TO) finish_txn(1'b1);
`endif
        end
    endtask

    task automatic new_req(input int i);
        req_valid_i[i]         = 1'b1;
        req_we_i[i]            = 1'($urandom_range(0, 1));
        req_addr_i[i*LW +: LW] = 16'($urandom);
        req_data_i[i*DW +: DW] = rnd128();
    endtask

    // Requesters hold until their done; the bus answers after a latency.
    task automatic drive();
        bus_valid_i = 1'b0;
        if (rnd_mode) rst_i = ($urandom_range(0, 99) == 0);
        for (int i = 0; i < REQ_NUM; i++) begin
            if (m_done[i]) begin
                if (hold_mask[i]) new_req(i);
                else req_valid_i[i] = 1'b0;
            end else if (rnd_mode && !req_valid_i[i] && !m_grant[i] && $urandom_range(0, 3) == 0) begin
                new_req(i);
            end else if (rnd_mode && req_valid_i[i] && m_grant[i] && $urandom_range(0, 15) == 0) begin
                req_valid_i[i] = 1'b0;
            end
        end
        if (m_new) lat_cnt = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 5));
        if (m_busy && auto_bus && lat_cnt > 0) begin
            lat_cnt--;
            if (lat_cnt == 0) begin
                bus_valid_i = 1'b1;
                bus_data_i  = resp_fixed ? resp_data : rnd128();
            end
        end else if (!m_busy && rnd_mode && $urandom_range(0, 7) == 0) begin
            bus_valid_i = 1'b1;
            bus_data_i  = rnd128();
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        cyc++;
        chk_en = 1'b1;
        #1;
        drive();
    endtask

    task automatic drain();
        hold_mask = 3'b000;
        for (int k = 0; k < 300 && (req_valid_i != 3'b000 || m_busy); k++) cycle();
        cycle();
    endtask

    // Every cycle: DUT outputs must equal the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("grant", 128'(grant_o), 128'(m_grant));
            chk("done", 128'(done_o), 128'(m_done));
            chk("err", 128'(err_o), 128'(m_err));
            chk("bus_valid", 128'(bus_valid_o), 128'(m_bvalid));
            chk("rdata", 128'(rdata_o), 128'(m_rdata));
            if (m_bvalid) begin
                chk("bus_addr", 128'(bus_addr_o), 128'(m_addr));
                chk("bus_data", 128'(bus_data_o), 128'(m_data));
                chk("bus_we", 128'(bus_we_o), 128'(m_we));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1);
    end

    initial begin
        int         ng, nd, nbv;
        int         tg[3];
        logic [2:0] prev, after;
        logic [2:0] seq[3];
        bit         seen, seen_start, got, got_loader;

        rst_i = 1'b1; req_valid_i = 3'b000; req_we_i = 3'b000;
        req_addr_i = '0; req_data_i = '0; bus_data_i = '0; bus_valid_i = 1'b0;
        for (int i = 0; i < 3; i++) begin seq[i] = 3'b000; tg[i] = 0; end
        cycle(); cycle();
        chk("rst_grant", 128'(grant_o), 128'(3'b000));
        chk("rst_bus_valid", 128'(bus_valid_o), 128'(1'b0));
        chk("rst_rdata", 128'(rdata_o), 128'(0));
        chk("rst_done", 128'(done_o), 128'(3'b000));
        rst_i = 1'b0;
        cycle();

        // All three at once, latency 2: grants in base order, 3 cycles apart.
        fixed_lat = 2;
        for (int i = 0; i < REQ_NUM; i++) new_req(i);
        ng = 0; prev = grant_o;
        for (int k = 0; k < 60 && ng < 3; k++) begin
            cycle();
            if (grant_o != 3'b000 && prev == 3'b000) begin seq[ng] = grant_o; tg[ng] = cyc; ng++; end
            prev = grant_o;
        end
        chk("all3_count", 128'(ng), 128'(3));
        chk("all3_first", 128'(seq[0]), 128'(3'b001));
        chk("all3_second", 128'(seq[1]), 128'(3'b010));
        chk("all3_third", 128'(seq[2]), 128'(3'b100));
        chk("all3_gap1", 128'(tg[1] - tg[0]), 128'(3));
        chk("all3_gap2", 128'(tg[2] - tg[1]), 128'(3));
        drain();

        // Icache read of line 0x0040.
        resp_fixed = 1'b1; fixed_lat = 3;
        new_req(REQ_ICACHE);
        req_we_i[REQ_ICACHE] = 1'b0;
        req_addr_i[REQ_ICACHE*LW +: LW] = 16'h0040;
        seen = 1'b0; seen_start = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            cycle();
            if (bus_valid_o && !seen_start) begin
                seen_start = 1'b1;
                chk("ic_addr", 128'(bus_addr_o), 128'(16'h0040));
                chk("ic_we", 128'(bus_we_o), 128'(1'b0));
            end
            if (done_o != 3'b000) begin
                seen = 1'b1;
                chk("ic_done", 128'(done_o), 128'(3'b010));
                chk("ic_rdata", 128'(rdata_o), 128'(RD_CONST));
            end
        end
        chk("ic_seen", 128'(seen), 128'(1'b1));
        cycle();
        chk("ic_done_once", 128'(done_o), 128'(3'b000));
        resp_fixed = 1'b0;
        drain();

        // Spurious response while idle.
        bus_valid_i = 1'b1; bus_data_i = ~RD_CONST;
        cycle();
        chk("spur_done", 128'(done_o), 128'(3'b000));
        chk("spur_rdata", 128'(rdata_o), 128'(RD_CONST));
        cycle();
        chk("spur_rdata2", 128'(rdata_o), 128'(RD_CONST));

`ifdef BUS_SCHED_TIMEOUT_EN
        // Bus never answers: abort after TO busy cycles, then normal service.
        auto_bus = 1'b0;
        new_req(REQ_DCACHE);
        nbv = 0; got = 1'b0;
        for (int k = 0; k < 60 && !got; k++) begin
            cycle();
            if (bus_valid_o) nbv++;
            if (done_o != 3'b000) begin
                got = 1'b1;
                chk("to_done", 128'(done_o), 128'(3'b001));
                chk("to_err", 128'(err_o), 128'(1'b1));
                chk("to_rdata", 128'(rdata_o), 128'(RD_CONST));
            end
        end
        chk("to_busy_cycles", 128'(nbv), 128'(TO));
        auto_bus = 1'b1;
        cycle();
        new_req(REQ_DCACHE);
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            cycle();
            if (done_o != 3'b000) begin got = 1'b1; chk("to_after_err", 128'(err_o), 128'(1'b0)); end
        end
        chk("to_after_done", 128'(got), 128'(1'b1));
        drain();
`endif

        // Dcache hogs the bus; the loader must win its 9th arbitration.
        fixed_lat = 2; hold_mask = 3'b001;
        new_req(REQ_DCACHE); new_req(REQ_LOADER);
        nd = 0; got_loader = 1'b0; after = 3'b000; prev = grant_o;
        for (int k = 0; k < 200 && after == 3'b000; k++) begin
            cycle();
            if (grant_o != 3'b000 && prev == 3'b000) begin
                if (got_loader) after = grant_o;
                else if (grant_o == 3'b100) got_loader = 1'b1;
                else nd++;
            end
            if (got_loader && !req_valid_i[REQ_LOADER] && after == 3'b000) new_req(REQ_LOADER);
            prev = grant_o;
        end
        chk("starve_losses", 128'(nd), 128'(8));
        chk("starve_age_cleared", 128'(after), 128'(3'b001));
        drain();

        // Reset one cycle into a transaction.
        auto_bus = 1'b0;
        for (int i = 0; i < REQ_NUM; i++) new_req(i);
        for (int k = 0; k < 10 && !bus_valid_o; k++) cycle();
        cycle();
        rst_i = 1'b1;
        cycle();
        chk("rst_mid_bus_valid", 128'(bus_valid_o), 128'(1'b0));
        chk("rst_mid_done", 128'(done_o), 128'(3'b000));
        rst_i = 1'b0; auto_bus = 1'b1;
        for (int k = 0; k < 10 && grant_o == 3'b000; k++) cycle();
        chk("rst_first_grant", 128'(grant_o), 128'(3'b001));
        drain();

        // Random traffic with spurious responses, drops and resets.
        fixed_lat = 0; rnd_mode = 1'b1;
        for (int k = 0; k < 3000; k++) cycle();
        rnd_mode = 1'b0; rst_i = 1'b0;
        drain();
        chk("final_idle", 128'(bus_valid_o), 128'(1'b0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
